// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Shared types and constants for the SPI command sequencer.
//               Holds the sequencer state encoding, the 16-bit header word
//               layout {rw, addr, len} and the address/length field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int LEN_WIDTH  = 8;
    localparam int HDR_WIDTH  = 1 + ADDR_WIDTH + LEN_WIDTH;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_FETCH = 3'd2,
        RD_WAIT  = 3'd3,
        RD_SHIFT = 3'd4
    } state_t;

    // Header word: bit 15 = rw (1 = read), [14:8] = start address, [7:0] = burst length
    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } hdr_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_det
// Description : 1-bit rising-edge detector. The history flop resets to
//               RESET_VAL so that a signal idling at that level after reset
//               does not produce a spurious edge.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               d_i     - level input (synchronous to clk)
//               rise_o  - high while d_i=1 and its registered copy is 0
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_ctrl
// Description : Command sequencer between an SPI slave word interface and a
//               register file. A header word {rw, addr, len} starts a burst
//               write (len data words follow) or a burst read (each register
//               word is fetched, presented on tx_data_o, and shifted out by
//               the master's next dummy word). A chip-select rise mid-frame
//               aborts back to IDLE with a one-cycle frame_err_o pulse.
// Options     : `define SPI_CMD_TIMEOUT_EN adds an inter-word watchdog that
//               aborts a stalled WR / RD_SHIFT frame after TIMEOUT_CYCLES.
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               cs_i               - SPI chip-select (active low, synchronous)
//               rx_valid_i/rx_data_i - receive word level / data
//               tx_valid_o/tx_data_o - transmit load pulse / data
//               tx_ready_i         - transmit done pulse (not needed here)
//               reg_*              - register file write/read interface
//               busy_o             - high while a frame is in progress
//               frame_err_o        - one-cycle pulse on abort
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_ctrl #(
    parameter int DATA_SIZE      = 16,
    parameter int ADDR_WIDTH     = 7,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_i,
    input  logic                  rx_valid_i,
    input  logic [DATA_SIZE-1:0]  rx_data_i,
    output logic                  tx_valid_o,
    output logic [DATA_SIZE-1:0]  tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  reg_wr_en_o,
    output logic                  reg_rd_en_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_SIZE-1:0]  reg_wdata_o,
    input  logic [DATA_SIZE-1:0]  reg_rdata_i,
    input  logic                  reg_rd_valid_i,
    output logic                  busy_o,
    output logic                  frame_err_o
);

    import spi_cmd_pkg::*;

    // The header layout is fixed by the package; refuse inconsistent widths.
    if ((DATA_SIZE != 1 + ADDR_WIDTH + LEN_WIDTH) || (DATA_SIZE != $bits(hdr_t))) begin : g_cfg_check
        $error("spi_cmd_ctrl: DATA_SIZE must equal 1+ADDR_WIDTH+LEN_WIDTH and match hdr_t");
    end

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic                   tx_pend_q;
    logic                   tx_valid_q;
    logic [DATA_SIZE-1:0]   tx_data_q;
    logic                   wr_en_q;
    logic                   rd_en_q;
    logic [ADDR_WIDTH-1:0]  reg_addr_q;
    logic [DATA_SIZE-1:0]   wdata_q;
    logic                   ferr_q;

    logic                   w_rx_rise;
    logic                   w_cs_rise;
    logic                   w_word;
    logic                   w_timeout;
    logic                   w_abort;
    hdr_t                   w_hdr;
    logic                   w_unused_tx_ready;

    // rx_valid idles high between frames, so its history starts at 1.
    spi_edge_det #(.RESET_VAL(1'b1)) u_rx_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (rx_valid_i),
        .rise_o (w_rx_rise)
    );

    // cs idles high (deasserted), so its history also starts at 1.
    spi_edge_det #(.RESET_VAL(1'b1)) u_cs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_i),
        .rise_o (w_cs_rise)
    );

    assign w_word  = w_rx_rise & ~cs_i;
    assign w_hdr   = hdr_t'(rx_data_i);
    assign w_abort = (w_cs_rise | w_timeout) & (state_q != IDLE);

    // Transmit completion is implied by the master's next dummy word.
    assign w_unused_tx_ready = tx_ready_i;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Saturating cycles-since-last-word counter; only WR and RD_SHIFT wait on the master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (w_word || (state_q == IDLE)) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign w_timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) &&
                       ((state_q == WR) || (state_q == RD_SHIFT));
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            tx_pend_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            ferr_q     <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;

            if (w_abort) begin
                // Abort outranks everything, including a same-cycle word event;
                // a pending tx_valid is suppressed and late read data is dropped.
                state_q   <= IDLE;
                ferr_q    <= 1'b1;
                tx_pend_q <= 1'b0;
            end else begin
                // Read data lands in tx_data one cycle before the load pulse.
                if (tx_pend_q) begin
                    tx_valid_q <= 1'b1;
                    tx_pend_q  <= 1'b0;
                end

                case (state_q)
                    IDLE: begin
                        // len==0 is a no-op header: stay idle, no strobes.
                        if (w_word && (w_hdr.len != '0)) begin
                            addr_q  <= w_hdr.addr;
                            cnt_q   <= w_hdr.len;
                            state_q <= w_hdr.rw ? RD_FETCH : WR;
                        end
                    end
                    WR: begin
                        if (w_word) begin
                            wr_en_q    <= 1'b1;
                            reg_addr_q <= addr_q;
                            wdata_q    <= rx_data_i;
                            addr_q     <= addr_q + 1'b1;
                            cnt_q      <= cnt_q - 1'b1;
                            // cnt is at least 1 here, so the decrement never underflows.
                            if (cnt_q == LEN_WIDTH'(1)) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    RD_FETCH: begin
                        rd_en_q    <= 1'b1;
                        reg_addr_q <= addr_q;
                        state_q    <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (reg_rd_valid_i) begin
                            tx_data_q <= reg_rdata_i;
                            tx_pend_q <= 1'b1;
                            addr_q    <= addr_q + 1'b1;
                            cnt_q     <= cnt_q - 1'b1;
                            state_q   <= RD_SHIFT;
                        end
                    end
                    RD_SHIFT: begin
                        // The dummy word shifted out the presented word; its data is discarded.
                        if (w_word) begin
                            state_q <= (cnt_q != '0) ? RD_FETCH : IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign reg_wr_en_o = wr_en_q;
    assign reg_rd_en_o = rd_en_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_err_o = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_cmd_ctrl
// Description : Self-checking bench for spi_cmd_ctrl. Acts as SPI master and
//               as the register file; checks a table of directed frames,
//               hand-written abort/reset/timeout sequences and random frames
//               against an address-arithmetic model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ctrl;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int LW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b1;
    logic          rx_valid = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready = 1'b0;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata = '0;
    logic          reg_rd_valid = 1'b0;
    logic          busy;
    logic          frame_err;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(
        .DATA_SIZE      (DW),
        .ADDR_WIDTH     (AW),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cs_i           (cs),
        .rx_valid_i     (rx_valid),
        .rx_data_i      (rx_data),
        .tx_valid_o     (tx_valid),
        .tx_data_o      (tx_data),
        .tx_ready_i     (tx_ready),
        .reg_wr_en_o    (reg_wr_en),
        .reg_rd_en_o    (reg_rd_en),
        .reg_addr_o     (reg_addr),
        .reg_wdata_o    (reg_wdata),
        .reg_rdata_i    (reg_rdata),
        .reg_rd_valid_i (reg_rd_valid),
        .busy_o         (busy),
        .frame_err_o    (frame_err)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] env_regs   [128];   // register file as seen by the DUT
    logic [DW-1:0] model_regs [128];   // register file predicted by the bench

    logic [AW-1:0] got_wr_addr[$], exp_wr_addr[$], got_rd_addr[$], exp_rd_addr[$];
    logic [DW-1:0] got_wr_data[$], exp_wr_data[$], got_tx[$], exp_tx[$];
    int            ferr_cnt = 0;
    logic          busy_seen = 1'b0;

    // Observe DUT strobes between clock edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en) begin
                got_wr_addr.push_back(reg_addr);
                got_wr_data.push_back(reg_wdata);
                env_regs[reg_addr] = reg_wdata;
            end
            if (reg_rd_en) got_rd_addr.push_back(reg_addr);
            if (tx_valid)  got_tx.push_back(tx_data);
            if (frame_err) ferr_cnt++;
            if (busy)      busy_seen = 1'b1;
        end
    end

    // Register file read responder with random 1..6 cycle latency.
    logic [AW-1:0] rsp_addr;
    int            rsp_dly;
    always begin
        @(negedge clk);
        if (rst_n && reg_rd_en) begin
            rsp_addr = reg_addr;
            rsp_dly  = $urandom_range(1, 6);
            repeat (rsp_dly) @(posedge clk);
            #1;
            reg_rdata    = env_regs[rsp_addr];
            reg_rd_valid = 1'b1;
            @(posedge clk);
            #1;
            reg_rd_valid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One SPI word: rx_valid low while bits shift, then high with the word.
    task automatic send_word(input logic [DW-1:0] w);
        rx_valid = 1'b0;
        tick(3);
        rx_data  = w;
        rx_valid = 1'b1;
        tick(3);
        tx_ready = 1'b1;   // unmatched completion pulse, must be ignored
        tick(1);
        tx_ready = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (got_tx.size() < n && t < 300) begin
            tick(1);
            t++;
        end
        chk($sformatf("tx word %0d presented", n), 32'(got_tx.size() >= n), 32'd1);
    endtask

    task automatic clear_q();
        got_wr_addr.delete(); got_wr_data.delete(); got_rd_addr.delete(); got_tx.delete();
        exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete(); exp_tx.delete();
        busy_seen = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(d);
        model_regs[a] = d;
    endtask

    task automatic run_frame(input logic [DW-1:0] hdr, input logic [3:0][DW-1:0] d, input int n);
        cs = 1'b0;
        tick(2);
        send_word(hdr);
        for (int i = 0; i < n; i++) begin
            if (hdr[15]) wait_tx(i + 1);
            send_word(d[i]);
        end
        tick(4);
        cs = 1'b1;
        tick(4);
    endtask

    task automatic check_frame(input string name);
        chk({name, " wr count"}, 32'(got_wr_addr.size()), 32'(exp_wr_addr.size()));
        for (int i = 0; i < exp_wr_addr.size() && i < got_wr_addr.size(); i++) begin
            chk($sformatf("%s wr addr %0d", name, i), 32'(got_wr_addr[i]), 32'(exp_wr_addr[i]));
            chk($sformatf("%s wr data %0d", name, i), 32'(got_wr_data[i]), 32'(exp_wr_data[i]));
        end
        chk({name, " rd count"}, 32'(got_rd_addr.size()), 32'(exp_rd_addr.size()));
        for (int i = 0; i < exp_rd_addr.size() && i < got_rd_addr.size(); i++)
            chk($sformatf("%s rd addr %0d", name, i), 32'(got_rd_addr[i]), 32'(exp_rd_addr[i]));
        chk({name, " tx count"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            chk($sformatf("%s tx data %0d", name, i), 32'(got_tx[i]), 32'(exp_tx[i]));
        chk({name, " busy idle"}, 32'(busy), 32'd0);
        clear_q();
    endtask

    typedef struct {
        logic [DW-1:0]       hdr;
        int                  n;          // data words (write) or dummy words (read)
        logic [3:0][DW-1:0]  data;       // data[0] is sent first
        int                  exp_n;
        logic [3:0][AW-1:0]  exp_addr;   // expected strobe addresses in order
        logic [3:0][DW-1:0]  exp_val;    // expected write data or tx data
    } vec_t;

    vec_t tbl[6];

    initial begin
        int               f0;
        logic             rw;
        logic [AW-1:0]    a, ea;
        int               len;
        logic [3:0][DW-1:0] d;

        for (int i = 0; i < 128; i++) begin
            env_regs[i]   = '0;
            model_regs[i] = '0;
        end

        // Packed arrays list the last element first: {[3],[2],[1],[0]}.
        tbl[0].hdr = 16'h0503; tbl[0].n = 3; tbl[0].data = {16'h0, 16'h3333, 16'h2222, 16'h1111};
        tbl[0].exp_n = 3; tbl[0].exp_addr = {7'h0, 7'h07, 7'h06, 7'h05}; tbl[0].exp_val = {16'h0, 16'h3333, 16'h2222, 16'h1111};
        tbl[1].hdr = 16'h7F02; tbl[1].n = 2; tbl[1].data = {16'h0, 16'h0, 16'hBBBB, 16'hAAAA};
        tbl[1].exp_n = 2; tbl[1].exp_addr = {7'h0, 7'h0, 7'h00, 7'h7F}; tbl[1].exp_val = {16'h0, 16'h0, 16'hBBBB, 16'hAAAA};
        tbl[2].hdr = 16'h2000; tbl[2].n = 0; tbl[2].data = '0;
        tbl[2].exp_n = 0; tbl[2].exp_addr = '0; tbl[2].exp_val = '0;
        tbl[3].hdr = 16'h0A02; tbl[3].n = 2; tbl[3].data = {16'h0, 16'h0, 16'hCAFE, 16'hBEEF};
        tbl[3].exp_n = 2; tbl[3].exp_addr = {7'h0, 7'h0, 7'h0B, 7'h0A}; tbl[3].exp_val = {16'h0, 16'h0, 16'hCAFE, 16'hBEEF};
        tbl[4].hdr = 16'h8A02; tbl[4].n = 2; tbl[4].data = {16'h0, 16'h0, 16'hD002, 16'hD001};
        tbl[4].exp_n = 2; tbl[4].exp_addr = {7'h0, 7'h0, 7'h0B, 7'h0A}; tbl[4].exp_val = {16'h0, 16'h0, 16'hCAFE, 16'hBEEF};
        tbl[5].hdr = 16'hFF02; tbl[5].n = 2; tbl[5].data = {16'h0, 16'h0, 16'hD004, 16'hD003};
        tbl[5].exp_n = 2; tbl[5].exp_addr = {7'h0, 7'h0, 7'h00, 7'h7F}; tbl[5].exp_val = {16'h0, 16'h0, 16'hBBBB, 16'hAAAA};

        // Reset state
        tick(3);
        chk("reset busy", 32'(busy), 0);
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset tx_data", 32'(tx_data), 0);
        chk("reset wr_en", 32'(reg_wr_en), 0);
        chk("reset rd_en", 32'(reg_rd_en), 0);
        chk("reset addr", 32'(reg_addr), 0);
        chk("reset wdata", 32'(reg_wdata), 0);
        chk("reset frame_err", 32'(frame_err), 0);
        rst_n = 1'b1;
        tick(3);
        chk("post-reset busy", 32'(busy), 0);
        chk("post-reset no frame_err", 32'(ferr_cnt), 0);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            clear_q();
            for (int i = 0; i < tbl[v].exp_n; i++) begin
                if (tbl[v].hdr[15]) begin
                    exp_rd_addr.push_back(tbl[v].exp_addr[i]);
                    exp_tx.push_back(tbl[v].exp_val[i]);
                end else begin
                    expect_wr(tbl[v].exp_addr[i], tbl[v].exp_val[i]);
                end
            end
            f0 = ferr_cnt;
            run_frame(tbl[v].hdr, tbl[v].data, tbl[v].n);
            if (tbl[v].exp_n == 0) chk($sformatf("vec%0d no-op busy", v), 32'(busy_seen), 0);
            chk($sformatf("vec%0d frame_err", v), 32'(ferr_cnt - f0), 0);
            check_frame($sformatf("vec%0d", v));
        end

        // Abort: len 4 write, cs rises after two data words
        clear_q();
        f0 = ferr_cnt;
        cs = 1'b0;
        tick(2);
        send_word(16'h1004);
        send_word(16'h5A01);
        send_word(16'h5A02);
        cs = 1'b1;
        tick(6);
        expect_wr(7'h10, 16'h5A01);
        expect_wr(7'h11, 16'h5A02);
        chk("abort frame_err pulses", 32'(ferr_cnt - f0), 1);
        check_frame("abort");
        f0 = ferr_cnt;
        expect_wr(7'h20, 16'h7777);
        run_frame(16'h2001, {16'h0, 16'h0, 16'h0, 16'h7777}, 1);
        chk("after-abort frame_err", 32'(ferr_cnt - f0), 0);
        check_frame("after-abort");

        // cs rise coincident with a word: abort wins, the word is not written
        f0 = ferr_cnt;
        cs = 1'b0;
        tick(2);
        send_word(16'h3003);
        send_word(16'h4401);
        rx_valid = 1'b0;
        tick(3);
        rx_data  = 16'h4402;
        rx_valid = 1'b1;
        cs       = 1'b1;
        tick(6);
        expect_wr(7'h30, 16'h4401);
        chk("cs+word frame_err", 32'(ferr_cnt - f0), 1);
        check_frame("cs+word");

        // Asynchronous reset in the middle of a read burst
        f0 = ferr_cnt;
        cs = 1'b0;
        tick(2);
        send_word(16'h8A04);
        wait_tx(1);
        chk("mid-read tx word", 32'(tx_data), 32'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 0);
        chk("async rst tx_data", 32'(tx_data), 0);
        chk("async rst addr", 32'(reg_addr), 0);
        chk("async rst rd_en", 32'(reg_rd_en), 0);
        chk("async rst tx_valid", 32'(tx_valid), 0);
        cs = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(12);
        chk("reset no frame_err", 32'(ferr_cnt - f0), 0);
        clear_q();

`ifdef SPI_CMD_TIMEOUT_EN
        // Watchdog: stall inside a write burst
        f0 = ferr_cnt;
        cs = 1'b0;
        tick(2);
        send_word(16'h3C03);
        send_word(16'h1234);
        tick(40);
        chk("timeout not early busy", 32'(busy), 1);
        chk("timeout not early ferr", 32'(ferr_cnt - f0), 0);
        tick(40);
        chk("timeout frame_err", 32'(ferr_cnt - f0), 1);
        expect_wr(7'h3C, 16'h1234);
        check_frame("timeout");
        cs = 1'b1;
        tick(4);
`endif

        // Random frames against the model
        for (int r = 0; r < 24; r++) begin
            clear_q();
            rw  = 1'($urandom_range(0, 1));
            a   = 7'($urandom_range(0, 127));
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            d   = '0;
            for (int i = 0; i < len; i++) begin
                d[i] = 16'($urandom);
                ea   = 7'((int'(a) + i) % 128);
                if (rw) begin
                    exp_rd_addr.push_back(ea);
                    exp_tx.push_back(model_regs[ea]);
                end else begin
                    expect_wr(ea, d[i]);
                end
            end
            f0 = ferr_cnt;
            run_frame({rw, a, 8'(len)}, d, len);
            chk($sformatf("rand%0d frame_err", r), 32'(ferr_cnt - f0), 0);
            check_frame($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI slave word interface and the accelerator register file.
- Decodes 16-bit header words from the SPI receive side into burst register writes or burst register reads.
- For reads, fetches register data and hands each word to the SPI transmit side.
- Aborts cleanly when chip-select deasserts mid-frame.

Parameters:
- DATA_SIZE, 16: SPI word width; must equal 1+ADDR_WIDTH+LEN_WIDTH.
- ADDR_WIDTH, 7: register address width.
- LEN_WIDTH, 8: burst length field width.
- TIMEOUT_CYCLES, 4096: inter-word watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  SPI chip-select, active low, already synchronous to clk.
- rx_valid  in  1  level; high while the slave's receive bit index is 0; a new word is the rising edge.
- rx_data  in  DATA_SIZE  received word; stable while rx_valid is high.
- tx_valid  out  1  one-cycle pulse; the slave loads tx_data on its rising edge.
- tx_data  out  DATA_SIZE  word to shift out on MISO.
- tx_ready  in  1  pulse from the slave after the last bit of a tx word.
- reg_wr_en  out  1  register write strobe, one cycle.
- reg_rd_en  out  1  register read strobe, one cycle.
- reg_addr  out  ADDR_WIDTH  register address.
- reg_wdata  out  DATA_SIZE  write data.
- reg_rdata  in  DATA_SIZE  read data.
- reg_rd_valid  in  1  read data valid; arrives 1..N cycles after reg_rd_en.
- busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values: all outputs 0; rx edge-detect flop resets to 1, so the idle-high rx_valid does not produce a word event; state IDLE.
- Word event: rx_valid==1 and its registered copy==0, qualified with cs==0.
- Header layout: [15] rw (1=read), [14:8] addr, [7:0] len. len==0 means no-op: stay in IDLE, no strobes.
- Unmatched tx_ready is ignored.

State machine:
- IDLE: on a word event, latch addr and cnt=len.
  - rw=0 → WR.
  - rw=1 → RD_FETCH.
- WR: each word event drives reg_wr_en=1, reg_addr=addr, reg_wdata=rx_data in the following cycle (latency 1). Then addr+=1 and cnt-=1. When cnt reaches 0 → IDLE.
- RD_FETCH: pulse reg_rd_en with reg_addr=addr for one cycle → RD_WAIT.
- RD_WAIT: on reg_rd_valid, tx_data<=reg_rdata, then tx_valid pulses in the next cycle.
  - addr+=1, cnt-=1 → RD_SHIFT.
  - tx_data holds until its next load.
- RD_SHIFT: wait for a word event (the master's dummy word, which shifted out the presented word).
  - cnt!=0 → RD_FETCH.
  - cnt==0 → IDLE.
  - The dummy rx_data is discarded.
- The fetch-to-present path must complete within one SPI word time; 16 SPI bits at 12:1 is 192 clk. The register file guarantees reg_rd_valid within 32 cycles.

Arithmetic:
- addr increments modulo 2^ADDR_WIDTH (127 wraps to 0).
- cnt never underflows.

Abort and reset:
- cs rising (1 while its registered copy is 0) in any non-IDLE state → IDLE next cycle, frame_err pulse.
- No strobe is issued in the abort cycle. A reg_rd_valid arriving afterwards is dropped.
- cs rise and a word event in the same cycle: abort wins.
- Asynchronous reset mid-frame returns to IDLE immediately; partial writes already strobed stay committed.

Optional Feature:
- Macro SPI_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every word event and in IDLE, and increments otherwise.
  - Reaching TIMEOUT_CYCLES in WR or RD_SHIFT aborts exactly like a cs rise: IDLE plus frame_err.
- Undefined: no counter; frames end only on cnt==0 or cs rise.

Decomposition:
- Package spi_cmd_pkg:
  - state enum (IDLE, WR, RD_FETCH, RD_WAIT, RD_SHIFT);
  - packed header struct {rw, addr, len};
  - ADDR_WIDTH and LEN_WIDTH constants.
- One sub-module, spi_edge_det: 1-bit rising-edge detector with reset value parameter, used for rx_valid and cs.

Test Plan:
- Write burst: header 0x0503 then words 0x1111, 0x2222, 0x3333 → reg_wr_en to addrs 0x05, 0x06, 0x07 with that data; busy drops after the third.
- Read burst: header 0x8A02 with regfile[0x0A]=0xBEEF, [0x0B]=0xCAFE, 2 dummies → tx_data 0xBEEF then 0xCAFE, each with one tx_valid pulse, two reg_rd_en pulses.
- Wrap: header 0x7F02, writes 0xAAAA and 0xBBBB → addrs 0x7F then 0x00.
- No-op: header 0x2000 → no strobes, busy stays 0, the next header is accepted normally.
- Abort: write header with len 4, cs rises after 2 data words → 2 writes only, frame_err one pulse, a new frame after cs low succeeds.
- Reset and timeout: rst_n low mid-read → all outputs 0 asynchronously. With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=64, stall 64 cycles in WR → frame_err pulse, IDLE.
